// File: rtl/hotp_digits.sv
// hotp_digits: HOTP dynamic truncation of an HMAC-SHA1 digest followed by a
// 31-step double-dabble conversion to a DIGITS-wide packed BCD code.
//
// Ports:
//   clk    in   1          rising-edge clock
//   reset  in   1          asynchronous active-low reset
//   start  in   1          request a new conversion (accepted in IDLE/DONE)
//   hash   in   160        digest, byte 0 = hash[159:152], byte 19 = hash[7:0]
//   trunc  out  31         dynamic-truncation value P
//   code   out  4*DIGITS   P mod 10^DIGITS as packed BCD, MS digit on top
//   busy   out  1          conversion in progress
//   done   out  1          trunc/code valid (level)
module hotp_digits #(
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [159:0]          hash,
  output logic [30:0]           trunc,
  output logic [4*DIGITS-1:0]   code,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned HASH_W  = 160;
  localparam int unsigned P_W     = 31;
  localparam int unsigned NIBBLES = 10;
  localparam int unsigned BCD_W   = 4 * NIBBLES;
  localparam int unsigned CODE_W  = 4 * DIGITS;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned SHAMT_W = 8;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(P_W - 1);

  if ((DIGITS < 1) || (DIGITS > 9)) begin : g_bad_digits
    $error("hotp_digits: DIGITS must be in 1..9");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXTRACT,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_busy;
  logic                r_done;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  logic [HASH_W-1:0]   r_hash;
  logic [P_W-1:0]      r_trunc;
  logic [P_W-1:0]      r_shift;
  logic [BCD_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic [CODE_W-1:0]   r_code;

  logic [SHAMT_W-1:0]  w_shamt;
  logic [P_W-1:0]      w_p;
  logic [BCD_W-1:0]    w_adj;
  logic [BCD_W-1:0]    w_step;

  // State register with registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and flag decode; start is only honoured from IDLE/DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_EXTRACT;
      S_EXTRACT:      w_state_nxt = S_CONVERT;
      S_CONVERT:      if (r_cnt == LAST_STEP) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_EXTRACT) || (w_state_nxt == S_CONVERT);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Byte window offset..offset+3 lands in the low 32 bits after a right
  // shift of 128 - 8*offset; truncating to 31 bits forces bit 31 to zero.
  always_comb begin
    w_shamt = SHAMT_W'(128) - {1'b0, r_hash[3:0], 3'b000};
    w_p     = P_W'(r_hash >> w_shamt);
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in next P bit.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_step = BCD_W'({w_adj, r_shift[P_W-1]});
  end

  // Datapath; code is written only on the final step so partial BCD never shows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hash  <= '0;
      r_trunc <= '0;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_code  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) r_hash <= hash;
        end
        S_EXTRACT: begin
          r_trunc <= w_p;
          r_shift <= w_p;
          r_bcd   <= '0;
          r_cnt   <= '0;
        end
        S_CONVERT: begin
          r_bcd   <= w_step;
          r_shift <= {r_shift[P_W-2:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) r_code <= w_step[CODE_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign trunc = r_trunc;
  assign code  = r_code;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_hotp_digits.sv
// tb_hotp_digits: self-checking bench for hotp_digits, with DIGITS=6 and
// DIGITS=8 instances sharing one stimulus, checked against an arithmetic
// model of HOTP truncation and decimal reduction.
module tb_hotp_digits;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [159:0] hash = '0;

  logic [30:0]  trunc6, trunc8;
  logic [23:0]  code6;
  logic [31:0]  code8;
  logic         busy6, busy8, done6, done8;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [159:0] H_A = 160'h1f8698690e02ca16618550ef7f19da8e945b555a;
  localparam logic [159:0] H_B = 160'hcc93cf18508d94934c64b65d8ba7667fb7cde4b0;

  hotp_digits #(.DIGITS(6)) u_dut6 (
    .clk(clk), .reset(reset), .start(start), .hash(hash),
    .trunc(trunc6), .code(code6), .busy(busy6), .done(done6)
  );

  hotp_digits #(.DIGITS(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .hash(hash),
    .trunc(trunc8), .code(code8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  // Reference: P from bytes offset..offset+3, big-endian, top bit dropped.
  function automatic logic [30:0] ref_p(input logic [159:0] h);
    int unsigned off;
    logic [31:0] w;
    logic [7:0]  b;
    off = int'(h[3:0]);
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = h[159 - 8*(off + k) -: 8];
      w = {w[23:0], b};
    end
    return w[30:0];
  endfunction

  // Reference: low d decimal digits of p as packed BCD.
  function automatic logic [35:0] ref_code(input logic [30:0] p, input int d);
    longint unsigned v;
    logic [35:0] r;
    v = 64'(p);
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [159:0] rand_hash();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Launch one operation and count edges after the start edge until done.
  task automatic run_op(input logic [159:0] h, output int lat,
                        output bit code_moved, output bit busy_bad);
    logic [23:0] c0;
    c0 = code6;
    code_moved = 1'b0;
    busy_bad = 1'b0;
    @(negedge clk);
    hash = h;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hash = rand_hash();
    if (done6 || !busy6) busy_bad = 1'b1;
    lat = 0;
    while (!done6 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done6 && code6 !== c0) code_moved = 1'b1;
      if (!done6 && !busy6) busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy6, done6, trunc6, code6, busy8, done8, trunc8, code8} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b trunc=%h code=%h, expected all zero",
               busy6, done6, trunc6, code6);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_known();
    int lat; bit moved, bb;
    run_op(H_A, lat, moved, bb);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL known_latency: got %0d expected 32", lat); end
    n_cmp++; if (trunc6 !== 31'h50ef7f19) begin n_bad++; $display("FAIL known_trunc: got %h expected 50ef7f19", trunc6); end
    n_cmp++; if (code6 !== 24'h872921) begin n_bad++; $display("FAIL known_code6: got %h expected 872921", code6); end
    n_cmp++; if (code8 !== 32'h57872921) begin n_bad++; $display("FAIL known_code8: got %h expected 57872921", code8); end
    n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL code_stable_during_convert: got moved=%b expected 0", moved); end
    n_cmp++; if (bb !== 1'b0 || busy6 !== 1'b0) begin n_bad++; $display("FAIL busy_profile: got bad=%b busy_at_done=%b expected 0/0", bb, busy6); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (done6 !== 1'b1 || code6 !== 24'h872921) begin n_bad++; $display("FAIL done_hold: got done=%b code=%h expected 1/872921", done6, code6); end
    run_op(H_B, lat, moved, bb);
    n_cmp++; if (code6 !== 24'h755224) begin n_bad++; $display("FAIL rfc_count0: got %h expected 755224", code6); end
    n_cmp++; if (lat !== 32 || bb !== 1'b0) begin n_bad++; $display("FAIL restart_from_done: got lat=%0d busy_bad=%b expected 32/0", lat, bb); end
  endtask

  task automatic test_boundary();
    int lat; bit moved, bb;
    logic [159:0] h;
    h = rand_hash();
    h[159:128] = 32'hffffffff;
    h[3:0] = 4'h0;
    run_op(h, lat, moved, bb);
    n_cmp++; if (trunc6 !== 31'h7fffffff) begin n_bad++; $display("FAIL off0_trunc: got %h expected 7fffffff", trunc6); end
    n_cmp++; if (code6 !== 24'h483647) begin n_bad++; $display("FAIL off0_code6: got %h expected 483647", code6); end
    n_cmp++; if (code8 !== 32'h47483647) begin n_bad++; $display("FAIL off0_code8: got %h expected 47483647", code8); end
    h = rand_hash();
    h[39:8] = 32'h00000007;
    h[3:0] = 4'hf;
    run_op(h, lat, moved, bb);
    n_cmp++; if (trunc6 !== 31'h7) begin n_bad++; $display("FAIL offF_trunc: got %h expected 0000007", trunc6); end
    n_cmp++; if (code6 !== 24'h000007) begin n_bad++; $display("FAIL offF_code6: got %h expected 000007", code6); end
    n_cmp++; if (code8 !== 32'h00000007) begin n_bad++; $display("FAIL offF_code8: got %h expected 00000007", code8); end
  endtask

  task automatic test_random();
    int lat; bit moved, bb;
    logic [159:0] h;
    logic [30:0]  p;
    for (int i = 0; i < 16; i++) begin
      h = rand_hash();
      if (i < 3) h[3:0] = 4'(13 + i);
      p = ref_p(h);
      run_op(h, lat, moved, bb);
      n_cmp++; if (trunc6 !== p || trunc8 !== p) begin n_bad++; $display("FAIL rand_trunc[%0d]: got %h/%h expected %h", i, trunc6, trunc8, p); end
      n_cmp++; if (code6 !== ref_code(p, 6)) begin n_bad++; $display("FAIL rand_code6[%0d]: got %h expected %h", i, code6, ref_code(p, 6)); end
      n_cmp++; if (code8 !== ref_code(p, 8)) begin n_bad++; $display("FAIL rand_code8[%0d]: got %h expected %h", i, code8, ref_code(p, 8)); end
      n_cmp++; if (lat !== 32 || moved || bb || done8 !== 1'b1) begin n_bad++; $display("FAIL rand_timing[%0d]: got lat=%0d moved=%b busy_bad=%b done8=%b expected 32/0/0/1", i, lat, moved, bb, done8); end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [159:0] h1, h2;
    h1 = rand_hash();
    h2 = rand_hash();
    @(negedge clk);
    hash = h1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done6 && lat < 40) begin
      if (lat == 10) begin start = 1'b1; hash = h2; end
      else start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL ignore_start_latency: got %0d expected 32", lat); end
    n_cmp++; if (code6 !== ref_code(ref_p(h1), 6) || trunc6 !== ref_p(h1)) begin n_bad++; $display("FAIL ignore_start_result: got %h/%h expected %h/%h", trunc6, code6, ref_p(h1), ref_code(ref_p(h1), 6)); end
  endtask

  task automatic test_start_held();
    int lat;
    logic [159:0] h1, h2;
    h1 = rand_hash();
    h2 = rand_hash();
    @(negedge clk);
    hash = h1;
    start = 1'b1;
    @(posedge clk);
    #1;
    hash = h2;
    lat = 0;
    while (!done6 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 32 || code6 !== ref_code(ref_p(h1), 6)) begin n_bad++; $display("FAIL held_first: got lat=%0d code=%h expected 32/%h", lat, code6, ref_code(ref_p(h1), 6)); end
    @(posedge clk);
    #1;
    n_cmp++; if (done6 !== 1'b0 || busy6 !== 1'b1) begin n_bad++; $display("FAIL held_reaccept: got done=%b busy=%b expected 0/1", done6, busy6); end
    lat = 0;
    while (!done6 && lat < 40) begin @(posedge clk); #1; lat++; end
    start = 1'b0;
    n_cmp++; if (lat !== 32 || code6 !== ref_code(ref_p(h2), 6)) begin n_bad++; $display("FAIL held_second: got lat=%0d code=%h expected 32/%h", lat, code6, ref_code(ref_p(h2), 6)); end
  endtask

  task automatic test_reset_mid();
    int lat; bit moved, bb, spurious;
    logic [159:0] h;
    h = rand_hash();
    @(negedge clk);
    hash = h;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy6, done6, trunc6, code6, busy8, done8, trunc8, code8} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_async: got busy=%b done=%b trunc=%h code=%h expected all zero",
               busy6, done6, trunc6, code6);
    end
    @(negedge clk);
    reset = 1'b1;
    spurious = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done6 || busy6 || done8) spurious = 1'b1;
    end
    n_cmp++; if (spurious !== 1'b0) begin n_bad++; $display("FAIL mid_reset_no_done: got spurious=%b expected 0", spurious); end
    run_op(h, lat, moved, bb);
    n_cmp++; if (lat !== 32 || code6 !== ref_code(ref_p(h), 6) || code8 !== ref_code(ref_p(h), 8)) begin n_bad++; $display("FAIL after_reset_op: got lat=%0d code6=%h code8=%h expected 32/%h/%h", lat, code6, code8, ref_code(ref_p(h), 6), ref_code(ref_p(h), 8)); end
  endtask

  initial begin
    test_reset();
    test_known();
    test_boundary();
    test_random();
    test_ignore_start();
    test_start_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
